// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_Q registered-output FIFOs onto one valid/ready channel, up to BURST words per grant.
// Latency: push-to-out_valid 3 cycles from idle ARB; 3 cycles per word within a burst, +1 cycle between grants.
// Backpressure: out_ready low holds the word in OUT; no further pops until the handshake.
module fifo_rr_drain #(
    parameter int WIDTH       = 8,
    parameter int NUM_Q       = 4,
    parameter int ID_WIDTH    = 2,
    parameter int BURST       = 4,
    parameter int BURST_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_Q-1:0]       fifo_empty,
    input  logic [NUM_Q*WIDTH-1:0] fifo_q,
    output logic [NUM_Q-1:0]       fifo_pop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_WIDTH-1:0]    out_src,
    output logic                   busy
);

    typedef enum logic [1:0] {S_ARB, S_SETTLE, S_CAPTURE, S_OUT} state_t;

    localparam logic [ID_WIDTH:0]      NQ        = (ID_WIDTH+1)'(NUM_Q);
    localparam logic [ID_WIDTH-1:0]    LAST_Q    = ID_WIDTH'(NUM_Q-1);
    localparam logic [BURST_WIDTH-1:0] BURST_LIM = BURST_WIDTH'(BURST);

    state_t                 state;
    logic [ID_WIDTH-1:0]    grant;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic [ID_WIDTH-1:0]    pick;
    logic                   pick_vld;
    logic [ID_WIDTH:0]      wrap_idx;
    logic [WIDTH-1:0]       q_arr [NUM_Q];

    for (genvar i = 0; i < NUM_Q; i++) begin : g_q
        assign q_arr[i] = fifo_q[i*WIDTH +: WIDTH];
    end

    // Walk offsets from far to near so the nearest non-empty queue after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        wrap_idx = '0;
        for (int k = NUM_Q-1; k >= 0; k--) begin
            wrap_idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
            if (wrap_idx >= NQ) begin
                wrap_idx = wrap_idx - NQ;
            end
            if (!fifo_empty[wrap_idx[ID_WIDTH-1:0]]) begin
                pick     = wrap_idx[ID_WIDTH-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (state == S_CAPTURE) begin
            fifo_pop[grant] = 1'b1;
        end
    end

    assign busy = (state != S_ARB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ARB;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (en && pick_vld) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                        state     <= S_SETTLE;
                    end
                end
                // q follows the head one cycle after a pointer move; wait it out.
                S_SETTLE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    out_data  <= q_arr[grant];
                    out_src   <= grant;
                    out_valid <= 1'b1;
                    burst_cnt <= burst_cnt + 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (en && !fifo_empty[grant] && (burst_cnt < BURST_LIM)) begin
                            state <= S_SETTLE;
                        end else begin
                            rr_ptr <= (grant == LAST_Q) ? '0 : grant + 1'b1;
                            state  <= S_ARB;
                        end
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: four behavioural registered-q FIFOs feed the DUT, handshakes are logged and checked per scenario.
module tb_fifo_rr_drain;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] fifo_empty;
    logic [31:0] fifo_q;
    logic [3:0] fifo_pop;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       busy;

    fifo_rr_drain #(.WIDTH(8), .NUM_Q(4), .ID_WIDTH(2), .BURST(4), .BURST_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_pop(fifo_pop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: q registered from the head entry every cycle
    logic [7:0] mem [4][16];
    logic [7:0] fq [4];
    int         rdp [4];
    int         wrp [4];
    int         cnt [4];
    logic [3:0] push = '0;
    logic [7:0] push_dat [4];
    int         pop_cnt = 0;
    int         uf_cnt = 0;
    int         push_total = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            fq[i] <= mem[i][rdp[i]];
            if (push[i]) begin
                mem[i][wrp[i]] <= push_dat[i];
                wrp[i] <= (wrp[i] + 1) % 16;
            end
            if (fifo_pop[i]) begin
                rdp[i] <= (rdp[i] + 1) % 16;
                pop_cnt <= pop_cnt + 1;
                if (cnt[i] == 0) uf_cnt <= uf_cnt + 1;
            end
            cnt[i] <= cnt[i] + (push[i] ? 1 : 0) - (fifo_pop[i] ? 1 : 0);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_q[i*8 +: 8] = fq[i];
            fifo_empty[i]    = (cnt[i] == 0);
        end
    end

    // Handshake log
    int         cyc = 0;
    logic [7:0] hs_data [$];
    logic [1:0] hs_src [$];
    int         hs_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_src.push_back(out_src);
            hs_cyc.push_back(cyc);
        end
    end

    int n_run = 0;
    int n_fail = 0;

    task automatic clear_log();
        hs_data.delete();
        hs_src.delete();
        hs_cyc.delete();
    endtask

    task automatic push_word(input int q, input logic [7:0] d);
        push_dat[q] = d;
        push[q] = 1'b1;
        @(negedge clk);
        push[q] = 1'b0;
        push_total++;
    endtask

    task automatic wait_hs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (hs_data.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (out_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset_initial();
        #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_run++; if (fifo_pop !== 4'b0) begin n_fail++; $display("FAIL rst_pop: got %b want 0000", fifo_pop); end
        n_run++; if ({out_src, out_data} !== 10'h0) begin n_fail++; $display("FAIL rst_out: got src %0d data %02h want 0/00", out_src, out_data); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        en = 1'b1; out_ready = 1'b1;
        push_word(2, 8'hA5);
        n_run++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL sw_t0: got busy/valid %b want 00", {busy, out_valid}); end
        @(negedge clk);
        n_run++; if ({busy, fifo_pop} !== 5'b1_0000) begin n_fail++; $display("FAIL sw_t1: got busy %0b pop %b want 1 0000", busy, fifo_pop); end
        @(negedge clk);
        n_run++; if ({out_valid, fifo_pop} !== 5'b0_0100) begin n_fail++; $display("FAIL sw_t2: got valid %0b pop %b want 0 0100", out_valid, fifo_pop); end
        @(negedge clk);
        n_run++; if ({out_valid, out_src, out_data, fifo_pop} !== {1'b1, 2'd2, 8'hA5, 4'b0000}) begin
            n_fail++; $display("FAIL sw_t3: got valid %0b src %0d data %02h pop %b want 1 2 a5 0000", out_valid, out_src, out_data, fifo_pop); end
        @(negedge clk);
        n_run++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL sw_t4: got valid/busy %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        en = 1'b1; out_ready = 1'b0;
        push_word(3, 8'h3A);
        wait_valid(20, ok);
        n_run++; if (!ok || out_src !== 2'd3) begin n_fail++; $display("FAIL rm_pre: got valid %0b src %0d want 1 3", out_valid, out_src); end
        push_word(0, 8'hC0);
        push_word(3, 8'h3B);
        #2 rst = 1'b0;
        #1;
        n_run++; if ({out_valid, busy, fifo_pop} !== 6'b0) begin
            n_fail++; $display("FAIL rm_async: got valid %0b busy %0b pop %b want 0 0 0000", out_valid, busy, fifo_pop); end
        @(negedge clk);
        clear_log();
        rst = 1'b1; out_ready = 1'b1;
        wait_hs(2, 40, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL rm_timeout: got %0d handshakes want 2", hs_data.size()); end
        n_run++; if ({hs_src[0], hs_data[0]} !== {2'd0, 8'hC0}) begin n_fail++; $display("FAIL rm_first: got src %0d data %02h want 0 c0", hs_src[0], hs_data[0]); end
        n_run++; if ({hs_src[1], hs_data[1]} !== {2'd3, 8'h3B}) begin n_fail++; $display("FAIL rm_second: got src %0d data %02h want 3 3b", hs_src[1], hs_data[1]); end
    endtask

    task automatic test_burst_limit();
        bit ok;
        int want_gap [5] = '{3, 3, 3, 4, 3};
        en = 1'b1; out_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 6; i++) push_word(0, 8'h10 + 8'(i));
        wait_hs(6, 60, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL bl_timeout: got %0d handshakes want 6", hs_data.size()); end
        for (int i = 0; i < 6; i++) begin
            n_run++; if ({hs_src[i], hs_data[i]} !== {2'd0, 8'h10 + 8'(i)}) begin
                n_fail++; $display("FAIL bl_word%0d: got src %0d data %02h want 0 %02h", i, hs_src[i], hs_data[i], 8'h10 + 8'(i)); end
        end
        for (int i = 0; i < 5; i++) begin
            n_run++; if (hs_cyc[i+1] - hs_cyc[i] !== want_gap[i]) begin
                n_fail++; $display("FAIL bl_gap%0d: got %0d want %0d", i, hs_cyc[i+1] - hs_cyc[i], want_gap[i]); end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        en = 1'b0; out_ready = 1'b1;
        push_word(0, 8'h40); push_word(1, 8'h41); push_word(3, 8'h43);
        clear_log(); en = 1'b1;
        wait_hs(3, 60, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL rr1_timeout: got %0d want 3", hs_data.size()); end
        n_run++; if ({hs_src[0], hs_src[1], hs_src[2]} !== {2'd0, 2'd1, 2'd3}) begin
            n_fail++; $display("FAIL rr1_order: got %0d %0d %0d want 0 1 3", hs_src[0], hs_src[1], hs_src[2]); end
        n_run++; if ({hs_data[0], hs_data[1], hs_data[2]} !== 24'h40_41_43) begin
            n_fail++; $display("FAIL rr1_data: got %02h %02h %02h want 40 41 43", hs_data[0], hs_data[1], hs_data[2]); end
        en = 1'b0;
        push_word(3, 8'h53); push_word(0, 8'h50);
        clear_log(); en = 1'b1;
        wait_hs(2, 40, ok);
        n_run++; if (!ok || {hs_src[0], hs_data[0], hs_src[1], hs_data[1]} !== {2'd0, 8'h50, 2'd3, 8'h53}) begin
            n_fail++; $display("FAIL rr2_order: got %0d/%02h %0d/%02h want 0/50 3/53", hs_src[0], hs_data[0], hs_src[1], hs_data[1]); end
        clear_log();
        push_word(1, 8'h61);
        wait_hs(1, 20, ok);
        en = 1'b0;
        push_word(0, 8'h70); push_word(3, 8'h73);
        clear_log(); en = 1'b1;
        wait_hs(2, 40, ok);
        n_run++; if (!ok || {hs_src[0], hs_data[0], hs_src[1], hs_data[1]} !== {2'd3, 8'h73, 2'd0, 8'h70}) begin
            n_fail++; $display("FAIL rr_wrap: got %0d/%02h %0d/%02h want 3/73 0/70", hs_src[0], hs_data[0], hs_src[1], hs_data[1]); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int p0;
        en = 1'b1; out_ready = 1'b0;
        clear_log();
        push_word(1, 8'h77); push_word(1, 8'h78);
        wait_valid(20, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got valid 0 want 1"); end
        p0 = pop_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_run++; if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 8'h77}) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid %0b src %0d data %02h want 1 1 77", c, out_valid, out_src, out_data); end
        end
        n_run++; if (pop_cnt !== p0) begin n_fail++; $display("FAIL bp_nopop: got %0d pops want %0d", pop_cnt, p0); end
        out_ready = 1'b1;
        @(negedge clk);
        n_run++; if (hs_data.size() !== 1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_one: got %0d handshakes valid %0b want 1 0", hs_data.size(), out_valid); end
        wait_hs(2, 20, ok);
        n_run++; if (!ok || {hs_data[0], hs_src[1], hs_data[1]} !== {8'h77, 2'd1, 8'h78}) begin
            n_fail++; $display("FAIL bp_seq: got %02h %0d/%02h want 77 1/78", hs_data[0], hs_src[1], hs_data[1]); end
    endtask

    task automatic test_enable();
        bit ok;
        int p0;
        en = 1'b0; out_ready = 1'b1;
        clear_log();
        push_word(1, 8'h88);
        p0 = pop_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_run++; if ({busy, out_valid} !== 2'b00 || pop_cnt !== p0) begin
                n_fail++; $display("FAIL en_block%0d: got busy %0b valid %0b pops %0d want 0 0 %0d", c, busy, out_valid, pop_cnt, p0); end
        end
        en = 1'b1;
        wait_hs(1, 20, ok);
        n_run++; if (!ok || {hs_src[0], hs_data[0]} !== {2'd1, 8'h88}) begin
            n_fail++; $display("FAIL en_resume: got %0d/%02h want 1/88", hs_src[0], hs_data[0]); end
        clear_log();
        out_ready = 1'b0;
        push_word(2, 8'h91); push_word(2, 8'h92);
        wait_valid(20, ok);
        en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        n_run++; if (!ok || hs_data.size() !== 1 || hs_data[0] !== 8'h91) begin
            n_fail++; $display("FAIL en_inflight: got %0d handshakes data %02h want 1 91", hs_data.size(), hs_data[0]); end
        p0 = pop_cnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_run++; if ({busy, out_valid} !== 2'b00 || pop_cnt !== p0) begin
                n_fail++; $display("FAIL en_noburst%0d: got busy %0b valid %0b pops %0d want 0 0 %0d", c, busy, out_valid, pop_cnt, p0); end
        end
        en = 1'b1;
        wait_hs(2, 20, ok);
        n_run++; if (!ok || {hs_src[1], hs_data[1]} !== {2'd2, 8'h92}) begin
            n_fail++; $display("FAIL en_regrant: got %0d/%02h want 2/92", hs_src[1], hs_data[1]); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_dat[i] = '0;
        test_reset_initial();
        test_single_word();
        test_reset_mid();
        test_burst_limit();
        test_round_robin();
        test_backpressure();
        test_enable();
        repeat (3) @(negedge clk);
        n_run++; if (uf_cnt !== 0) begin n_fail++; $display("FAIL underflow: got %0d want 0", uf_cnt); end
        n_run++; if (pop_cnt !== push_total || fifo_empty !== 4'hF) begin
            n_fail++; $display("FAIL drained: got pops %0d empty %b want %0d 1111", pop_cnt, fifo_empty, push_total); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
